// File: rtl/button_cmd_pkg.sv
// Shared constants, command codes and repeat-FSM state for the button command decoder.
package button_cmd_pkg;
  localparam int NUM_BUTTONS = 11;
  localparam int CMD_W       = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_START = 5;
  localparam int BTN_Z     = 6;
  localparam int BTN_Y     = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_B     = 9;
  localparam int BTN_C     = 10;

  localparam logic [CMD_W-1:0] CMD_NONE  = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ABORT = 4'd15;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  function automatic logic [3:0] lowest_index(input logic [NUM_BUTTONS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/button_command_decoder_repeat_timer.sv
// Auto-repeat for held direction buttons: tracks one direction, counts frames,
// and strobes repeat_event on the frame_tick where a repeat token is due.
module repeat_timer
  import button_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       abort,
  input  logic [3:0] pressed,
  input  logic [3:0] new_press,
  output logic [3:0] repeat_event
);

  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255 ||
      (REPEAT_DELAY - 1) > (2 ** CNT_W) - 1 || (REPEAT_RATE - 1) > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("repeat_timer: REPEAT_DELAY/REPEAT_RATE out of range or CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE - 1);

  rpt_state_t       state;
  logic [1:0]       track;
  logic [CNT_W-1:0] cnt;
  logic             fire;

  always_comb begin
    fire = frame_tick && !abort && pressed[track] &&
           ((state == RPT_DELAY && cnt == DELAY_END) ||
            (state == RPT_REPEAT && cnt == RATE_END));
    repeat_event = fire ? (4'b0001 << track) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RPT_IDLE;
      track <= '0;
      cnt   <= '0;
    end else if (frame_tick) begin
      if (abort) begin
        state <= RPT_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          RPT_IDLE: begin
            if (|new_press) begin
              track <= lowest_dir(new_press);
              cnt   <= '0;
              state <= RPT_DELAY;
            end
          end
          default: begin
            // Releasing the tracked direction hands over to any other held one without a token.
            if (!pressed[track]) begin
              cnt <= '0;
              if (|pressed) begin
                track <= lowest_dir(pressed);
                state <= RPT_DELAY;
              end else begin
                state <= RPT_IDLE;
              end
            end else if (fire) begin
              cnt   <= '0;
              state <= RPT_REPEAT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_command_decoder.sv
// Frame-sampled button edge/repeat to command-token decoder with a valid/ready output slot.
// Optional combo abort (A+B+C+Start -> code 15) is enabled by defining COMBO_ABORT_EN.
module button_command_decoder
  import button_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] buttons_in,
  input  logic        frame_tick,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  input  logic        cmd_ready,
  output logic [10:0] held_mask,
  output logic        overflow
);

  logic [NUM_BUTTONS-1:0] pressed, prev_pressed, new_press, events;
  logic [NUM_BUTTONS-1:0] pending, pending_next, clear_mask;
  logic [3:0]             rep_event, low_idx;
  logic                   slot_free, combo_fire, take_abort, load_pend, ovf_hit;
`ifdef COMBO_ABORT_EN
  logic                   abort_q;
  localparam logic [NUM_BUTTONS-1:0] COMBO_MASK = NUM_BUTTONS'((1 << BTN_A) | (1 << BTN_START) |
                                                               (1 << BTN_B) | (1 << BTN_C));
`endif

  repeat_timer #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_repeat_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .abort       (combo_fire),
    .pressed     (pressed[3:0]),
    .new_press   (new_press[3:0]),
    .repeat_event(rep_event)
  );

  always_comb begin
    pressed   = ~buttons_in;
    new_press = pressed & ~prev_pressed;
    events    = frame_tick ? (new_press | {{(NUM_BUTTONS-4){1'b0}}, rep_event}) : '0;
    slot_free = !cmd_valid || cmd_ready;
    low_idx   = lowest_index(pending);

    combo_fire = 1'b0;
    take_abort = 1'b0;
`ifdef COMBO_ABORT_EN
    combo_fire = frame_tick && ((pressed & COMBO_MASK) == COMBO_MASK) && |(new_press & COMBO_MASK);
    take_abort = slot_free && abort_q;
`endif

    // On the abort tick nothing is taken from pending, so the ABORT token comes out first.
    load_pend  = slot_free && |pending && !combo_fire && !take_abort;
    clear_mask = load_pend ? (NUM_BUTTONS'(1) << low_idx) : '0;
    ovf_hit    = !combo_fire && |(events & pending & ~clear_mask);
    pending_next = combo_fire ? '0 : ((pending & ~clear_mask) | events);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pressed <= '1;
      held_mask    <= '0;
      pending      <= '0;
      overflow     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_code     <= CMD_NONE;
`ifdef COMBO_ABORT_EN
      abort_q      <= 1'b0;
`endif
    end else begin
      if (frame_tick) begin
        prev_pressed <= pressed;
        held_mask    <= pressed;
      end
      pending <= pending_next;
      if (ovf_hit) overflow <= 1'b1;

      if (take_abort) begin
        cmd_valid <= 1'b1;
        cmd_code  <= CMD_ABORT;
      end else if (load_pend) begin
        cmd_valid <= 1'b1;
        cmd_code  <= low_idx + 4'd1;
      end else if (slot_free) begin
        cmd_valid <= 1'b0;
        cmd_code  <= CMD_NONE;
      end

`ifdef COMBO_ABORT_EN
      if (combo_fire) abort_q <= 1'b1;
      else if (take_abort) abort_q <= 1'b0;
`endif
    end
  end

endmodule
